// File: rtl/fx_bc_mp.sv
// fx bus master: buffers decoded codec commands in a FIFO and replays them as
// single or burst fx write/read cycles on a one-hot selected device channel.
module fx_bc_mp #(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int NDEV   = 4,
  parameter int RD_LAT = 2,
  parameter int FDEPTH = 4
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic [7:0]      cmd_dev,
  input  logic [7:0]      cmd_mod,
  input  logic [7:0]      cmd_addr,
  input  logic [DW-1:0]   cmd_data,
  input  logic            cmd_rw,
  input  logic [3:0]      cmd_len,
  input  logic            cmd_vld,
  output logic            cmd_rdy,
  output logic [DW-1:0]   cmd_q,
  output logic            cmd_qvld,
  output logic            cmd_err,
  output logic            busy,
  output logic [NDEV-1:0] fx_cs,
  output logic [AW-1:0]   fx_waddr,
  output logic            fx_wr,
  output logic [DW-1:0]   fx_data,
  output logic            fx_rd,
  output logic [AW-1:0]   fx_raddr,
  input  logic [DW-1:0]   fx_q
);

  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam logic [PW-1:0]   PTR_ONE  = 1;
  localparam logic [PW:0]     CNT_ONE  = 1;
  localparam logic [PW:0]     CNT_FULL = (PW+1)'(FDEPTH);
  localparam logic [NDEV-1:0] CS_ONE   = 1;
  localparam logic [3:0]      LAT_M1   = 4'(RD_LAT - 1);
  localparam logic [3:0]      LAT_END  = 4'(RD_LAT);

  typedef struct packed {
    logic [7:0]    dev;
    logic [7:0]    mod;
    logic [7:0]    addr;
    logic [DW-1:0] data;
    logic          rw;
    logic [3:0]    len;
  } entry_t;

  typedef enum logic [2:0] {IDLE, CHECK, WR, RD_ISS, RD_WAIT, DONE} state_t;

  state_t        state, state_nxt;
  entry_t        fifo_mem [FDEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_nxt;
  logic          push, pop;
  logic          issue_wr, issue_rd, set_cs, clr_cs, err_nxt, sample;

  logic [7:0]    w_dev, w_mod, beat_addr;
  logic [DW-1:0] w_data;
  logic          w_rw;
  logic [3:0]    beats_left, lat_cnt;
  logic          dev_bad;

  // Command FIFO
  assign push = cmd_vld & cmd_rdy;
  assign head = fifo_mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= '{cmd_dev, cmd_mod, cmd_addr, cmd_data, cmd_rw, cmd_len};
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_ONE;
    else if (!push && pop) count_nxt = count - CNT_ONE;
  end

  // cmd_rdy is registered, so a pop from a full FIFO reopens it one cycle later
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_nxt;
      cmd_rdy <= (count_nxt != CNT_FULL);
    end
  end

  assign busy    = (state != IDLE) || (count != '0);
  assign dev_bad = (w_dev >= 8'(NDEV));

  // Sequencer
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue_wr  = 1'b0;
    issue_rd  = 1'b0;
    set_cs    = 1'b0;
    clr_cs    = 1'b0;
    err_nxt   = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (dev_bad) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          set_cs = 1'b1;
          if (w_rw) begin
            issue_rd  = 1'b1;
            state_nxt = RD_ISS;
          end else begin
            issue_wr  = 1'b1;
            state_nxt = WR;
          end
        end
      end
      WR: begin
        if (beats_left != 4'd0) issue_wr  = 1'b1;
        else                    state_nxt = DONE;
      end
      RD_ISS: state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (lat_cnt == LAT_M1) sample = 1'b1;
        if (lat_cnt == LAT_END) begin
          if (beats_left != 4'd0) begin
            issue_rd  = 1'b1;
            state_nxt = RD_ISS;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        clr_cs    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working copy of the popped command; only consulted after a pop
  always_ff @(posedge clk_sys) begin
    if (pop) begin
      w_dev     <= head.dev;
      w_mod     <= head.mod;
      w_data    <= head.data;
      w_rw      <= head.rw;
      beat_addr <= head.addr;
    end else if (issue_wr || issue_rd) begin
      beat_addr <= beat_addr + 8'd1;
    end
  end

  // Bus outputs; the first beat is issued from CHECK, so beats_left starts at len
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      beats_left <= '0;
      lat_cnt    <= '0;
      fx_cs      <= '0;
      fx_wr      <= 1'b0;
      fx_rd      <= 1'b0;
      fx_waddr   <= '0;
      fx_raddr   <= '0;
      fx_data    <= '0;
      cmd_q      <= '0;
      cmd_qvld   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      if (pop)
        beats_left <= head.len;
      else if ((issue_wr || issue_rd) && state != CHECK)
        beats_left <= beats_left - 4'd1;

      if (state == RD_ISS)       lat_cnt <= '0;
      else if (state == RD_WAIT) lat_cnt <= lat_cnt + 4'd1;

      if (set_cs)      fx_cs <= CS_ONE << w_dev[2:0];
      else if (clr_cs) fx_cs <= '0;

      fx_wr <= issue_wr;
      fx_rd <= issue_rd;
      if (issue_wr) begin
        fx_waddr <= AW'({w_mod, beat_addr});
        fx_data  <= w_data;
      end
      if (issue_rd) fx_raddr <= AW'({w_mod, beat_addr});

      if (sample) cmd_q <= fx_q;
      cmd_qvld <= sample;
      cmd_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fx_bc_mp.sv
// Directed bench for fx_bc_mp: writes, bursts, reads, bad device, FIFO full, reset mid-burst.
module tb_fx_bc_mp;

  localparam int LAT = 2;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic [7:0]  cmd_dev = '0, cmd_mod = '0, cmd_addr = '0, cmd_data = '0;
  logic        cmd_rw  = 1'b0;
  logic [3:0]  cmd_len = '0;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy, cmd_qvld, cmd_err, busy, fx_wr, fx_rd;
  logic [7:0]  cmd_q, fx_data;
  logic [7:0]  fx_q = 8'hEE;
  logic [3:0]  fx_cs;
  logic [15:0] fx_waddr, fx_raddr;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [3:0]  wr_cs_q[$];
  int          wr_cyc_q[$];
  logic [15:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [7:0]  qv_q[$];
  int          qv_cyc_q[$];
  int          err_cyc_q[$];
  logic [3:0]  err_cs_q[$];
  int          both_cnt = 0;

  bit [7:0] h_addr [16];
  bit       h_vld  [16];

  always #5 clk_sys = ~clk_sys;

  fx_bc_mp dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .cmd_dev(cmd_dev), .cmd_mod(cmd_mod), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_rw(cmd_rw), .cmd_len(cmd_len), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_q(cmd_q), .cmd_qvld(cmd_qvld), .cmd_err(cmd_err), .busy(busy),
    .fx_cs(fx_cs), .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q)
  );

  // Bus monitor: one sample per cycle, away from the active edge
  always @(negedge clk_sys) begin
    ncyc++;
    if (fx_wr) begin
      wr_addr_q.push_back(fx_waddr);
      wr_data_q.push_back(fx_data);
      wr_cs_q.push_back(fx_cs);
      wr_cyc_q.push_back(ncyc);
    end
    if (fx_rd) begin
      rd_addr_q.push_back(fx_raddr);
      rd_cyc_q.push_back(ncyc);
    end
    if (cmd_qvld) begin
      qv_q.push_back(cmd_q);
      qv_cyc_q.push_back(ncyc);
    end
    if (cmd_err) begin
      err_cyc_q.push_back(ncyc);
      err_cs_q.push_back(fx_cs);
    end
    if (fx_wr && fx_rd) both_cnt++;
  end

  // Device model: returns the low read-address byte LAT cycles after fx_rd
  always @(posedge clk_sys) begin
    #1;
    for (int i = 15; i > 0; i--) begin
      h_addr[i] = h_addr[i-1];
      h_vld[i]  = h_vld[i-1];
    end
    h_addr[0] = fx_raddr[7:0];
    h_vld[0]  = fx_rd;
    fx_q = h_vld[LAT] ? h_addr[LAT] : 8'hEE;
  end

  task automatic push(input logic [7:0] dev, input logic [7:0] mod, input logic [7:0] addr,
                      input logic [7:0] data, input logic rw, input logic [3:0] len,
                      output int acc);
    int n;
    cmd_dev = dev; cmd_mod = mod; cmd_addr = addr; cmd_data = data;
    cmd_rw = rw; cmd_len = len; cmd_vld = 1'b1;
    n = 0;
    acc = -1;
    @(negedge clk_sys); #1;
    while (!cmd_rdy && n < 300) begin
      @(negedge clk_sys); #1;
      n++;
    end
    total++;
    if (cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL push_accept rdy=%b want 1", cmd_rdy);
    end else begin
      acc = ncyc;
    end
    @(posedge clk_sys); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk_sys); #1;
    while (busy && n < 1000) begin
      @(negedge clk_sys); #1;
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle busy=%b want 0", nm, busy);
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    #1;
    total++;
    if ({cmd_rdy, cmd_qvld, cmd_err, busy, fx_wr, fx_rd} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want 000000", {cmd_rdy, cmd_qvld, cmd_err, busy, fx_wr, fx_rd});
    end
    total++;
    if ({fx_cs, fx_waddr, fx_raddr, fx_data, cmd_q} !== 52'h0) begin
      bad++;
      $display("FAIL reset_data got=%h want 0", {fx_cs, fx_waddr, fx_raddr, fx_data, cmd_q});
    end
    #1 rst_n = 1'b1;
    @(negedge clk_sys); #1;
    total++;
    if (cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL reset_rdy_rise got=%b want 1", cmd_rdy);
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_single_write();
    int base, acc;
    base = wr_addr_q.size();
    push(8'd1, 8'h12, 8'h34, 8'hA5, 1'b0, 4'd0, acc);
    wait_idle("single_wr");
    total++;
    if (wr_addr_q.size() !== base + 1) begin
      bad++;
      $display("FAIL single_wr_count got=%0d want %0d", wr_addr_q.size(), base + 1);
    end else begin
      total++;
      if (wr_addr_q[base] !== 16'h1234 || wr_data_q[base] !== 8'hA5) begin
        bad++;
        $display("FAIL single_wr_addr_data got=%h/%h want 1234/a5", wr_addr_q[base], wr_data_q[base]);
      end
      total++;
      if (wr_cs_q[base] !== 4'b0010) begin
        bad++;
        $display("FAIL single_wr_cs got=%b want 0010", wr_cs_q[base]);
      end
      total++;
      if (wr_cyc_q[base] !== acc + 3) begin
        bad++;
        $display("FAIL single_wr_latency got=%0d want %0d", wr_cyc_q[base], acc + 3);
      end
    end
  endtask

  task automatic test_burst_write();
    int base, acc;
    logic [15:0] exp_addr [4];
    exp_addr = '{16'hABFE, 16'hABFF, 16'hAB00, 16'hAB01};
    base = wr_addr_q.size();
    push(8'd0, 8'hAB, 8'hFE, 8'h3C, 1'b0, 4'd3, acc);
    wait_idle("burst_wr");
    total++;
    if (wr_addr_q.size() !== base + 4) begin
      bad++;
      $display("FAIL burst_wr_count got=%0d want %0d", wr_addr_q.size(), base + 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wr_addr_q[base+i] !== exp_addr[i] || wr_data_q[base+i] !== 8'h3C ||
            wr_cs_q[base+i] !== 4'b0001 || wr_cyc_q[base+i] !== acc + 3 + i) begin
          bad++;
          $display("FAIL burst_wr_beat%0d got=%h/%h/%b@%0d want %h/3c/0001@%0d", i,
                   wr_addr_q[base+i], wr_data_q[base+i], wr_cs_q[base+i], wr_cyc_q[base+i],
                   exp_addr[i], acc + 3 + i);
        end
      end
    end
  endtask

  task automatic test_read();
    int rbase, qbase, wbase, acc;
    rbase = rd_addr_q.size();
    qbase = qv_q.size();
    wbase = wr_addr_q.size();
    push(8'd2, 8'h07, 8'h40, 8'h00, 1'b1, 4'd1, acc);
    wait_idle("read");
    total++;
    if (rd_addr_q.size() !== rbase + 2 || qv_q.size() !== qbase + 2) begin
      bad++;
      $display("FAIL read_counts got rd=%0d qv=%0d want 2/2", rd_addr_q.size() - rbase, qv_q.size() - qbase);
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (rd_addr_q[rbase+i] !== 16'h0740 + 16'(i) || rd_cyc_q[rbase+i] !== acc + 3 + 4*i) begin
          bad++;
          $display("FAIL read_strobe%0d got=%h@%0d want %h@%0d", i, rd_addr_q[rbase+i],
                   rd_cyc_q[rbase+i], 16'h0740 + 16'(i), acc + 3 + 4*i);
        end
        total++;
        if (qv_q[qbase+i] !== 8'h40 + 8'(i) || qv_cyc_q[qbase+i] !== acc + 6 + 4*i) begin
          bad++;
          $display("FAIL read_data%0d got=%h@%0d want %h@%0d", i, qv_q[qbase+i],
                   qv_cyc_q[qbase+i], 8'h40 + 8'(i), acc + 6 + 4*i);
        end
      end
    end
    total++;
    if (cmd_q !== 8'h41 || wr_addr_q.size() !== wbase) begin
      bad++;
      $display("FAIL read_hold got q=%h writes=%0d want 41/0", cmd_q, wr_addr_q.size() - wbase);
    end
  endtask

  task automatic test_bad_dev();
    int wbase, ebase, rbase, a1, a2;
    wbase = wr_addr_q.size();
    ebase = err_cyc_q.size();
    rbase = rd_addr_q.size();
    push(8'd5, 8'h22, 8'h10, 8'h99, 1'b0, 4'd0, a1);
    push(8'd3, 8'h22, 8'h11, 8'h77, 1'b0, 4'd0, a2);
    wait_idle("bad_dev");
    total++;
    if (err_cyc_q.size() !== ebase + 1) begin
      bad++;
      $display("FAIL bad_dev_err_count got=%0d want 1", err_cyc_q.size() - ebase);
    end else begin
      total++;
      if (err_cyc_q[ebase] !== a1 + 3 || err_cs_q[ebase] !== 4'b0000) begin
        bad++;
        $display("FAIL bad_dev_err got=%0d cs=%b want %0d cs=0000", err_cyc_q[ebase], err_cs_q[ebase], a1 + 3);
      end
    end
    total++;
    if (wr_addr_q.size() !== wbase + 1 || rd_addr_q.size() !== rbase) begin
      bad++;
      $display("FAIL bad_dev_strobes got wr=%0d rd=%0d want 1/0", wr_addr_q.size() - wbase, rd_addr_q.size() - rbase);
    end else begin
      total++;
      if (wr_addr_q[wbase] !== 16'h2211 || wr_data_q[wbase] !== 8'h77 ||
          wr_cs_q[wbase] !== 4'b1000 || wr_cyc_q[wbase] !== a2 + 4) begin
        bad++;
        $display("FAIL bad_dev_next got=%h/%h/%b@%0d want 2211/77/1000@%0d", wr_addr_q[wbase],
                 wr_data_q[wbase], wr_cs_q[wbase], wr_cyc_q[wbase], a2 + 4);
      end
    end
  endtask

  task automatic test_fifo_full();
    int wbase, a0, ai, exp_acc;
    logic [3:0] exp_cs;
    wbase = wr_addr_q.size();
    push(8'd3, 8'h50, 8'h00, 8'h11, 1'b0, 4'd15, a0);
    for (int i = 0; i < 4; i++) begin
      push(8'(i), 8'h60, 8'h10 + 8'(i), 8'h80 + 8'(i), 1'b0, 4'd0, ai);
      total++;
      if (ai !== a0 + 1 + i) begin
        bad++;
        $display("FAIL full_accept%0d got=%0d want %0d", i, ai, a0 + 1 + i);
      end
    end
    total++;
    if (cmd_rdy !== 1'b0) begin
      bad++;
      $display("FAIL full_rdy got=%b want 0", cmd_rdy);
    end
    push(8'd0, 8'h60, 8'h14, 8'h84, 1'b0, 4'd0, ai);
    exp_acc = a0 + 21;
    total++;
    if (ai !== exp_acc) begin
      bad++;
      $display("FAIL full_late_accept got=%0d want %0d", ai, exp_acc);
    end
    wait_idle("fifo_full");
    total++;
    if (wr_addr_q.size() !== wbase + 21) begin
      bad++;
      $display("FAIL full_wr_count got=%0d want 21", wr_addr_q.size() - wbase);
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (wr_addr_q[wbase+i] !== 16'h5000 + 16'(i) || wr_data_q[wbase+i] !== 8'h11 ||
            wr_cs_q[wbase+i] !== 4'b1000) begin
          bad++;
          $display("FAIL full_burst_beat%0d got=%h/%h/%b want %h/11/1000", i, wr_addr_q[wbase+i],
                   wr_data_q[wbase+i], wr_cs_q[wbase+i], 16'h5000 + 16'(i));
        end
      end
      for (int i = 0; i < 5; i++) begin
        exp_cs = 4'b0001 << (i % 4);
        total++;
        if (wr_addr_q[wbase+16+i] !== 16'h6010 + 16'(i) || wr_data_q[wbase+16+i] !== 8'h80 + 8'(i) ||
            wr_cs_q[wbase+16+i] !== exp_cs) begin
          bad++;
          $display("FAIL full_order%0d got=%h/%h/%b want %h/%h/%b", i, wr_addr_q[wbase+16+i],
                   wr_data_q[wbase+16+i], wr_cs_q[wbase+16+i], 16'h6010 + 16'(i), 8'h80 + 8'(i), exp_cs);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int wbase, acc, n;
    wbase = wr_addr_q.size();
    push(8'd2, 8'h33, 8'h00, 8'h5A, 1'b0, 4'd15, acc);
    n = 0;
    while (wr_addr_q.size() < wbase + 3 && n < 100) begin
      @(negedge clk_sys); #1;
      n++;
    end
    total++;
    if (wr_addr_q.size() !== wbase + 3 || fx_wr !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_reach got beats=%0d wr=%b want 3/1", wr_addr_q.size() - wbase, fx_wr);
    end else begin
      total++;
      if (wr_cyc_q[wbase+2] !== acc + 5 || wr_addr_q[wbase+2] !== 16'h3302) begin
        bad++;
        $display("FAIL rst_mid_beat3 got=%h@%0d want 3302@%0d", wr_addr_q[wbase+2], wr_cyc_q[wbase+2], acc + 5);
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({fx_wr, fx_rd, cmd_rdy, busy, fx_cs, fx_waddr, fx_data} !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_outputs got=%h want 0", {fx_wr, fx_rd, cmd_rdy, busy, fx_cs, fx_waddr, fx_data});
    end
    @(negedge clk_sys); #2;
    rst_n = 1'b1;
    repeat (25) @(negedge clk_sys);
    #1;
    total++;
    if (wr_addr_q.size() !== wbase + 3 || busy !== 1'b0 || cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_after got beats=%0d busy=%b rdy=%b want 3/0/1",
               wr_addr_q.size() - wbase, busy, cmd_rdy);
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_exclusive_strobes();
    total++;
    if (both_cnt !== 0) begin
      bad++;
      $display("FAIL wr_rd_overlap got=%0d want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_write();
    test_read();
    test_bad_dev();
    test_fifo_full();
    test_reset_mid();
    test_exclusive_strobes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", ncyc);
    $fatal(1, "watchdog");
  end

endmodule
